hann_frame_sequencer: RTL and testbench

- Frame-level driver that sits directly upstream of the Hann window stage in the spectrum-analyzer datapath.
- On a frame request it walks all 2^bw_x samples of the capture RAM. For each sample it reads it, launches one window operation, waits for that result, then writes the windowed result into the FFT input RAM (optionally bit-reversed).
- Operations are strictly one at a time, so the window stage's latency never matters.
- A watchdog aborts the frame if the window stage stops answering.

---
 rtl/hann_frame_sequencer_pkg.sv | 29 ++
 rtl/hann_frame_sequencer_bit_reverse_addr.sv | 13 +
 rtl/hann_frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_hann_frame_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hann_frame_sequencer_pkg.sv
// Shared analyzer definitions: sequencer state encoding, default widths and
// the index bit-reversal helper used by the sequencer and the FFT stage.
package analyzer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seqState_t;

    localparam int BW_X_DEFAULT    = 11;
    localparam int BW_DATA_DEFAULT = 16;

    // Reverses the low 'width' bits of value; bits above width come back as 0.
    function automatic logic [31:0] bitRev(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[width - 1 - i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hann_frame_sequencer_bit_reverse_addr.sv
// Combinational address bit-reverser spanning the full address width.
module bit_reverse_addr
    import analyzer_pkg::*;
#(
    parameter int Width = BW_X_DEFAULT
) (
    input  logic [Width-1:0] AddrIn,
    output logic [Width-1:0] AddrOut
);

    assign AddrOut = Width'(bitRev(32'(AddrIn), Width));

endmodule

// File: rtl/hann_frame_sequencer.sv
// Frame sequencer feeding the Hann window stage: reads each capture-RAM sample,
// runs one window operation at a time and writes the result into the FFT RAM.
module hann_frame_sequencer
    import analyzer_pkg::*;
#(
    parameter int bw_x        = BW_X_DEFAULT,
    parameter int bw_data     = BW_DATA_DEFAULT,
    parameter bit bit_reverse = 1'b1,
    parameter int bw_wdog     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               FrameStart,
    output logic               FrameBusy,
    output logic               FrameEnd,
    output logic               ErrTimeout,
    output logic               ErrReject,
    output logic               SrcRdEn,
    output logic [bw_x-1:0]    SrcAddr,
    input  logic [bw_data-1:0] SrcData,
    output logic               WinStart,
    output logic [bw_x-1:0]    WinX,
    output logic [bw_data-1:0] WinData,
    input  logic               WinEnd,
    input  logic [bw_data-1:0] WinOut,
    output logic               DstWe,
    output logic [bw_x-1:0]    DstAddr,
    output logic [bw_data-1:0] DstData
);
    // state | meaning
    // IDLE  | waiting for an accepted FrameStart
    // READ  | capture-RAM read of sample idx
    // LOAD  | hand sample to the window stage, pulse WinStart
    // WAIT  | waiting for WinEnd, watchdog running
    // WRITE | FFT-RAM write of the windowed sample
    // DONE  | FrameEnd pulse, return to IDLE

    localparam logic [bw_x-1:0]    idxLast  = '1;
    localparam logic [bw_wdog-1:0] wdogLast = {{(bw_wdog-1){1'b1}}, 1'b0};

    seqState_t           state, stateNext;
    logic [bw_x-1:0]     idx, idxNext, idxRev;
    logic [bw_wdog-1:0]  wdog, wdogNext;
    logic                busyNext, endNext, toNext, rejNext, rdNext, winStartNext, weNext;
    logic [bw_x-1:0]     srcAddrNext, winXNext, dstAddrNext;
    logic [bw_data-1:0]  winDataNext, dstDataNext;

    bit_reverse_addr #(.Width(bw_x)) uBitRev (
        .AddrIn  (idx),
        .AddrOut (idxRev)
    );

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        wdogNext     = wdog;
        busyNext     = FrameBusy;
        endNext      = 1'b0;
        toNext       = 1'b0;
        rejNext      = FrameStart && (state != IDLE);
        rdNext       = 1'b0;
        srcAddrNext  = SrcAddr;
        winStartNext = 1'b0;
        winXNext     = WinX;
        winDataNext  = WinData;
        weNext       = 1'b0;
        dstAddrNext  = DstAddr;
        dstDataNext  = DstData;
        case (state)
            IDLE: begin
                if (FrameStart) begin
                    idxNext     = '0;
                    busyNext    = 1'b1;
                    rdNext      = 1'b1;
                    srcAddrNext = '0;
                    stateNext   = READ;
                end
            end
            READ: stateNext = LOAD;
            LOAD: begin
                winDataNext  = SrcData;
                winXNext     = idx;
                winStartNext = 1'b1;
                wdogNext     = '0;
                stateNext    = WAIT;
            end
            WAIT: begin
                if (WinEnd) begin
                    dstDataNext = WinOut;
                    dstAddrNext = bit_reverse ? idxRev : idx;
                    weNext      = 1'b1;
                    stateNext   = WRITE;
                end else begin
                    wdogNext = wdog + 1'b1;
                    if (wdog == wdogLast) begin
                        toNext    = 1'b1;
                        busyNext  = 1'b0;
                        stateNext = IDLE;
                    end
                end
            end
            WRITE: begin
                if (idx == idxLast) begin
                    endNext   = 1'b1;
                    stateNext = DONE;
                end else begin
                    idxNext     = idx + 1'b1;
                    rdNext      = 1'b1;
                    srcAddrNext = idx + 1'b1;
                    stateNext   = READ;
                end
            end
            DONE: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            idx        <= '0;
            wdog       <= '0;
            FrameBusy  <= 1'b0;
            FrameEnd   <= 1'b0;
            ErrTimeout <= 1'b0;
            ErrReject  <= 1'b0;
            SrcRdEn    <= 1'b0;
            SrcAddr    <= '0;
            WinStart   <= 1'b0;
            WinX       <= '0;
            WinData    <= '0;
            DstWe      <= 1'b0;
            DstAddr    <= '0;
            DstData    <= '0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            wdog       <= wdogNext;
            FrameBusy  <= busyNext;
            FrameEnd   <= endNext;
            ErrTimeout <= toNext;
            ErrReject  <= rejNext;
            SrcRdEn    <= rdNext;
            SrcAddr    <= srcAddrNext;
            WinStart   <= winStartNext;
            WinX       <= winXNext;
            WinData    <= winDataNext;
            DstWe      <= weNext;
            DstAddr    <= dstAddrNext;
            DstData    <= dstDataNext;
        end
    end

endmodule

// File: tb/tb_hann_frame_sequencer.sv
// Scoreboard bench for hann_frame_sequencer: bit-reversed and natural-order
// instances run in lockstep against a capture-RAM and window-stage model.
module tb_hann_frame_sequencer;

    localparam int BX = 3;
    localparam int BD = 16;
    localparam int BW = 4;
    localparam int N  = 1 << BX;

    logic Clock = 1'b0;
    logic Reset, FrameStart, WinEnd;
    logic [BD-1:0] SrcData, WinOut;

    logic aBusy, aEnd, aTo, aRej, aRd, aWinStart, aWe;
    logic [BX-1:0] aSrcAddr, aWinX, aDstAddr;
    logic [BD-1:0] aWinData, aDstData;
    logic bBusy, bEnd, bTo, bRej, bRd, bWinStart, bWe;
    logic [BX-1:0] bSrcAddr, bWinX, bDstAddr;
    logic [BD-1:0] bWinData, bDstData;

    always #5 Clock = ~Clock;

    hann_frame_sequencer #(.bw_x(BX), .bw_data(BD), .bit_reverse(1'b1), .bw_wdog(BW)) dutA (
        .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .FrameBusy(aBusy),
        .FrameEnd(aEnd), .ErrTimeout(aTo), .ErrReject(aRej), .SrcRdEn(aRd),
        .SrcAddr(aSrcAddr), .SrcData(SrcData), .WinStart(aWinStart), .WinX(aWinX),
        .WinData(aWinData), .WinEnd(WinEnd), .WinOut(WinOut), .DstWe(aWe),
        .DstAddr(aDstAddr), .DstData(aDstData));

    hann_frame_sequencer #(.bw_x(BX), .bw_data(BD), .bit_reverse(1'b0), .bw_wdog(BW)) dutB (
        .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .FrameBusy(bBusy),
        .FrameEnd(bEnd), .ErrTimeout(bTo), .ErrReject(bRej), .SrcRdEn(bRd),
        .SrcAddr(bSrcAddr), .SrcData(SrcData), .WinStart(bWinStart), .WinX(bWinX),
        .WinData(bWinData), .WinEnd(WinEnd), .WinOut(WinOut), .DstWe(bWe),
        .DstAddr(bDstAddr), .DstData(bDstData));

    typedef struct {
        logic [BX-1:0] a;
        logic [BD-1:0] d;
    } wr_t;

    wr_t qA[$], qB[$];
    int endQ[$], toQ[$], rejQ[$], idleQ[$];
    int cyc = 0;
    int nChk = 0, nFail = 0;
    int doneTok = 0, doneSeen = 0;

    logic [BD-1:0] ram [N];
    int  lat [N];
    bit  withhold [N];
    bit  spurious = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Capture RAM (one-cycle read latency) and window stage (WinOut = WinData ^ 0xFFFF)
    logic          prevRd = 1'b0;
    logic [BX-1:0] prevAddr = '0;
    int            pending = 0;
    logic [BD-1:0] held = '0;
    always @(negedge Clock) begin
        SrcData  = prevRd ? ram[prevAddr] : BD'($urandom);
        prevRd   = aRd;
        prevAddr = aSrcAddr;
        WinEnd   = spurious;
        WinOut   = spurious ? 16'hDEAD : BD'($urandom);
        if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                WinEnd = 1'b1;
                WinOut = held ^ 16'hFFFF;
            end
        end
        if (aWinStart && !withhold[aWinX]) begin
            pending = lat[aWinX];
            held    = aWinData;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (aWe) begin
            if (qA.size() == 0) check("A write without expectation", 1, 0);
            else begin
                wr_t e;
                e = qA.pop_front();
                check("A DstAddr", 64'(aDstAddr), 64'(e.a));
                check("A DstData", 64'(aDstData), 64'(e.d));
                check("A FrameBusy during write", 64'(aBusy), 1);
            end
        end
        if (bWe) begin
            if (qB.size() == 0) check("B write without expectation", 1, 0);
            else begin
                wr_t e;
                e = qB.pop_front();
                check("B DstAddr", 64'(bDstAddr), 64'(e.a));
                check("B DstData", 64'(bDstData), 64'(e.d));
            end
        end
        if (aEnd) begin
            if (endQ.size() == 0) check("FrameEnd unexpected", 1, 0);
            else check("FrameEnd cycle", 64'(cyc), 64'(endQ.pop_front()));
        end
        if (aTo) begin
            if (toQ.size() == 0) check("ErrTimeout unexpected", 1, 0);
            else check("ErrTimeout cycle", 64'(cyc), 64'(toQ.pop_front()));
            check("FrameBusy at timeout", 64'(aBusy), 0);
        end
        if (aRej) begin
            if (rejQ.size() == 0) check("ErrReject unexpected", 1, 0);
            else check("ErrReject cycle", 64'(cyc), 64'(rejQ.pop_front()));
        end
        if (aEnd | aTo | aRej | bEnd | bTo | bRej)
            check("A/B pulses agree", 64'({aEnd, aTo, aRej}), 64'({bEnd, bTo, bRej}));
        if (idleQ.size() > 0 && idleQ[0] == cyc) begin
            void'(idleQ.pop_front());
            check("outputs zero after reset",
                  64'({aBusy, aEnd, aTo, aRej, aRd, aWinStart, aWe, aSrcAddr, aWinX,
                       aDstAddr, aWinData, aDstData}), 0);
        end
        if (doneTok != doneSeen) begin
            doneSeen = doneTok;
            check("A writes outstanding", 64'(qA.size()), 0);
            check("B writes outstanding", 64'(qB.size()), 0);
            check("FrameEnd outstanding", 64'(endQ.size()), 0);
            check("ErrTimeout outstanding", 64'(toQ.size()), 0);
            check("ErrReject outstanding", 64'(rejQ.size()), 0);
            check("reset checks outstanding", 64'(idleQ.size()), 0);
        end
    end

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < BX; b++)
            if ((k & (1 << b)) != 0) r |= 1 << (BX - 1 - b);
        return r;
    endfunction

    // READ cycle of sample k for a frame whose FrameStart was in cycle c
    function automatic int readCyc(input int c, input int k);
        int t = c + 1;
        for (int j = 0; j < k; j++) t += 4 + lat[j];
        return t;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge Clock);
    endtask

    task automatic setupFrame(input bit rnd, input int fixedLat);
        for (int i = 0; i < N; i++) begin
            ram[i] = rnd ? BD'($urandom) : BD'(16'h1000 + i);
            lat[i] = rnd ? int'($urandom_range(1, 8)) : fixedLat;
        end
    endtask

    task automatic startFrame(output int c, input int nWr);
        wr_t e;
        FrameStart = 1'b1;
        c = cyc;
        for (int k = 0; k < nWr; k++) begin
            e.d = ram[k] ^ 16'hFFFF;
            e.a = BX'(brev(k));
            qA.push_back(e);
            e.a = BX'(k);
            qB.push_back(e);
        end
        tick(1);
        FrameStart = 1'b0;
    endtask

    initial begin
        int c, c2, e, t;
        Reset = 1'b1;
        FrameStart = 1'b0;
        for (int i = 0; i < N; i++) begin
            withhold[i] = 1'b0;
            lat[i] = 1;
            ram[i] = '0;
        end
        tick(2);
        idleQ.push_back(cyc + 1);
        tick(2);
        Reset = 1'b0;
        tick(1);

        // full frame, 7 cycles per sample
        setupFrame(1'b0, 3);
        startFrame(c, N);
        endQ.push_back(readCyc(c, N));
        waitCyc(readCyc(c, N) + 2);

        // fastest window response
        setupFrame(1'b0, 1);
        startFrame(c, N);
        endQ.push_back(readCyc(c, N));
        waitCyc(readCyc(c, N) + 2);

        // window stage never answers sample 5
        setupFrame(1'b0, 3);
        withhold[5] = 1'b1;
        startFrame(c, 5);
        t = readCyc(c, 5) + 2 + 15;
        toQ.push_back(t);
        waitCyc(t + 3);
        withhold[5] = 1'b0;

        // FrameStart during WAIT of sample 2
        setupFrame(1'b0, 3);
        startFrame(c, N);
        endQ.push_back(readCyc(c, N));
        waitCyc(readCyc(c, 2) + 3);
        FrameStart = 1'b1;
        rejQ.push_back(cyc + 1);
        tick(1);
        FrameStart = 1'b0;
        waitCyc(readCyc(c, N) + 2);

        // reset during WRITE of sample 3, then a clean restart
        setupFrame(1'b1, 0);
        startFrame(c, 4);
        waitCyc(readCyc(c, 3) + 3 + lat[3]);
        Reset = 1'b1;
        idleQ.push_back(cyc + 1);
        tick(1);
        Reset = 1'b0;
        tick(2);
        setupFrame(1'b1, 0);
        startFrame(c, N);
        endQ.push_back(readCyc(c, N));
        waitCyc(readCyc(c, N) + 2);

        // spurious WinEnd in IDLE; FrameStart held through DONE and the following cycle
        setupFrame(1'b0, 2);
        spurious = 1'b1;
        tick(1);
        spurious = 1'b0;
        tick(2);
        startFrame(c, N);
        e = readCyc(c, N);
        endQ.push_back(e);
        waitCyc(e);
        FrameStart = 1'b1;
        rejQ.push_back(cyc + 1);
        tick(1);
        setupFrame(1'b1, 0);
        startFrame(c2, N);
        endQ.push_back(readCyc(c2, N));
        waitCyc(readCyc(c2, N) + 2);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            setupFrame(1'b1, 0);
            tick(int'($urandom_range(1, 4)));
            startFrame(c, N);
            endQ.push_back(readCyc(c, N));
            waitCyc(readCyc(c, N) + 1);
        end

        tick(3);
        doneTok++;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
